// File: rtl/barrel_pkg.sv
// ============================================================================
// Module   : barrel_pkg
// Brief    : Shared types for the pipelined barrel shifter (shift_op_t).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_pkg;

    typedef enum logic [1:0] {
        ROL = 2'b00,
        ROR = 2'b01,
        SRL = 2'b10,
        SRA = 2'b11
    } shift_op_t;

    localparam int c_n_min = 2;
    localparam int c_n_max = 6;

endpackage

`default_nettype wire

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// ============================================================================
// Module   : shift_stage
// Brief    : One combinational shift level of 2**K positions for a 2**N-bit word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import barrel_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 0
) (
    input  logic [2**N-1:0] d,
    input  logic            en,
    input  logic [1:0]      op,
    output logic [2**N-1:0] q
);

    localparam int c_w = 2**N;
    localparam int c_s = 2**K;

    // Arithmetic shifts reuse the current MSB: earlier SRA levels keep it equal to the original A[W-1].
    always_comb begin
        q = d;
        if (en) begin
            case (shift_op_t'(op))
                ROL:     q = {d[c_w-c_s-1:0], d[c_w-1:c_w-c_s]};
                ROR:     q = {d[c_s-1:0], d[c_w-1:c_s]};
                SRL:     q = {{c_s{1'b0}}, d[c_w-1:c_s]};
                SRA:     q = {{c_s{d[c_w-1]}}, d[c_w-1:c_s]};
                default: q = d;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : N-stage valid/ready barrel shifter (ROL/ROR/SRL/SRA); optional
//            result bit-reverse enabled by macro BSR_REVERSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**N-1:0]   A,
    input  logic [N-1:0]      AMT,
    input  logic [1:0]        op,
`ifdef BSR_REVERSE_EN
    input  logic              rev,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   Y
);

    localparam int c_w = 2**N;

    logic                    w_advance;
    logic [N-1:0]            r_valid;
    logic [N-1:0][c_w-1:0]   r_data;
    logic [N-1:0][N-1:0]     r_amt;
    logic [N-1:0][1:0]       r_op;

    logic [c_w-1:0]          w_stage_in  [N];
    logic [c_w-1:0]          w_stage_out [N];
    logic [N-1:0]            w_amt_in    [N];
    logic [1:0]              w_op_in     [N];
    logic                    w_valid_in  [N];
    logic [c_w-1:0]          w_last;
    logic                    w_unused;

    // Whole pipe moves or holds as one; no bubble compaction.
    assign w_advance = !r_valid[N-1] | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_valid[N-1];
    assign Y         = r_data[N-1];

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_stage_in[k] = A;
                assign w_amt_in[k]   = AMT;
                assign w_op_in[k]    = op;
                assign w_valid_in[k] = in_valid;
            end else begin : g_rest
                assign w_stage_in[k] = r_data[k-1];
                assign w_amt_in[k]   = r_amt[k-1];
                assign w_op_in[k]    = r_op[k-1];
                assign w_valid_in[k] = r_valid[k-1];
            end

            shift_stage #(
                .N (N),
                .K (k)
            ) u_shift_stage (
                .d  (w_stage_in[k]),
                .en (w_amt_in[k][k]),
                .op (w_op_in[k]),
                .q  (w_stage_out[k])
            );
        end
    endgenerate

`ifdef BSR_REVERSE_EN
    logic [N-2:0]   r_rev;
    logic           w_rev_in [N];
    logic [c_w-1:0] w_rev_out;

    generate
        for (genvar k = 0; k < N; k++) begin : g_rev
            if (k == 0) begin : g_first
                assign w_rev_in[k] = rev;
            end else begin : g_rest
                assign w_rev_in[k] = r_rev[k-1];
            end
        end
    endgenerate

    always_comb begin
        w_rev_out = w_stage_out[N-1];
        for (int i = 0; i < c_w; i++) begin
            w_rev_out[i] = w_stage_out[N-1][c_w-1-i];
        end
    end

    assign w_last = w_rev_in[N-1] ? w_rev_out : w_stage_out[N-1];
`else
    assign w_last = w_stage_out[N-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= '0;
`ifdef BSR_REVERSE_EN
            r_rev   <= '0;
`endif
        end else if (w_advance) begin
            for (int k = 0; k < N; k++) begin
                r_valid[k] <= w_valid_in[k];
                r_amt[k]   <= w_amt_in[k];
                r_op[k]    <= w_op_in[k];
                r_data[k]  <= (k == N-1) ? w_last : w_stage_out[k];
            end
`ifdef BSR_REVERSE_EN
            for (int k = 0; k < N-1; k++) begin
                r_rev[k] <= w_rev_in[k];
            end
`endif
        end
    end

    // Last-stage control fields are carried for uniformity but never consumed.
    assign w_unused = ^{r_amt, r_op[N-1]};

endmodule

`default_nettype wire
